toy_memory: RTL
===============

TOY_MEMORY -- requirements
Module: toy_memory

Interface
REQ-001 Parameter DEPTH_LOG2, default 5, gives 2**DEPTH_LOG2 bytes of storage (range 1..8).
REQ-002 Parameter WAIT_STATES, default 2, gives the number of wait cycles inserted before each transfer (range 0..15).
REQ-003 CLK  input  1  single system clock; all state changes on the rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 MEM_EN  input  1  processor access request; held high for the whole access.
REQ-006 WRITE_EN  input  1  access type; 1 = write, 0 = read; sampled with the address.
REQ-007 D_OUT  input  8  processor output bus; address byte in the request cycle, write data in the XFER cycle.
REQ-008 D_IN  output  8  read data to the processor; registered.
REQ-009 READY  output  1  access complete; registered.
REQ-010 BUSY  output  1  high in states ADDR, WAIT and XFER.
REQ-011 ERR  output  1  address out of range; valid while READY=1.

Function
REQ-012 The FSM SHALL have states IDLE, ADDR, WAIT, XFER and DONE, with a 4-bit wait counter.
REQ-013 IDLE, MEM_EN=1: latch address=D_OUT and wr=WRITE_EN, load counter=WAIT_STATES, go ADDR; otherwise stay in IDLE.
REQ-014 ADDR SHALL last exactly one cycle, then go WAIT if WAIT_STATES>0, else go XFER.
REQ-015 WAIT: counter SHALL decrement each cycle; go XFER on the cycle the counter reaches 0, so WAIT lasts exactly WAIT_STATES cycles.
REQ-016 XFER, write, address in range: mem[address] SHALL take D_OUT as sampled on this edge.
REQ-017 XFER, read, address in range: D_IN SHALL take mem[address].
REQ-018 XFER SHALL always go DONE.
REQ-019 An address >= 2**DEPTH_LOG2 is out of range: write suppressed, D_IN<=8'hFF on read, ERR=1 in DONE.
REQ-020 DONE: READY=1, and READY SHALL hold while MEM_EN=1 (four-phase handshake).
REQ-021 DONE: return to IDLE the cycle after MEM_EN=0; READY and ERR SHALL clear on that transition.
REQ-022 Latency: MEM_EN sampled high at edge N gives READY high after edge N+WAIT_STATES+3.
REQ-023 MEM_EN=0 while in ADDR, WAIT or XFER (before the XFER edge) SHALL abort: return to IDLE, no memory write, D_IN unchanged, READY stays 0.
REQ-024 A new access SHALL start only from IDLE; MEM_EN held high after DONE does not start a second access.
REQ-025 WRITE_EN and D_OUT changes outside the request and XFER cycles SHALL have no effect.
REQ-026 D_IN SHALL hold its last value except in a read XFER.

Reset
REQ-027 RESET=0 SHALL immediately force: state IDLE, counter 0, D_IN=8'h00, READY=0, BUSY=0, ERR=0.
REQ-028 Memory contents SHALL NOT be altered by reset.
REQ-029 Reset asserted mid-access SHALL cancel the access with no write; the first edge after release samples MEM_EN in IDLE.

Verification
REQ-030 Write then read: write 8'h3C to addr 8'h05, drop MEM_EN, then read addr 8'h05 -> READY after 5 edges, D_IN=8'h3C, ERR=0.
REQ-031 Out of range: write 8'hAA to addr 8'h20, then read 8'h20 -> ERR=1 both times, D_IN=8'hFF; a read of addr 8'h00 returns its prior value.
REQ-032 Abort: write 8'h77 to addr 8'h03 with MEM_EN dropped during WAIT -> BUSY falls, READY never rises, a read of 8'h03 returns its old data.
REQ-033 Handshake: hold MEM_EN high 4 cycles after READY -> READY stays 1 with no new access; READY falls 1 cycle after MEM_EN=0.
REQ-034 Reset mid-write: pull RESET low in WAIT -> outputs go to 0 asynchronously and the target byte is unchanged.
REQ-035 WAIT_STATES=0: read -> READY after 3 edges with correct data.

Source files
------------

// File: rtl/toy_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : toy_memory
// Description : Byte-wide scratch memory behind a four-phase processor
//               handshake. An access is requested by raising mem_en with the
//               address on d_out. It then passes through one address cycle,
//               WAIT_STATES wait cycles and one transfer cycle. In DONE, ready
//               is raised and held until mem_en drops. Addresses at or above
//               2**DEPTH_LOG2 report err, return 8'hFF on reads and never
//               write. Dropping mem_en before the transfer edge aborts the
//               access. Memory contents are not affected by reset.
//
// Parameters  : DEPTH_LOG2  - log2 of storage size in bytes (1..8)
//               WAIT_STATES - wait cycles inserted before each transfer (0..15)
//
// Ports       : clk      in   system clock, rising edge
//               reset    in   asynchronous, active-low reset
//               mem_en   in   access request, held for the whole access
//               write_en in   1 = write, 0 = read; sampled with the address
//               d_out    in   address byte (request cycle) / write data (XFER)
//               d_in     out  registered read data
//               ready    out  registered access-complete flag
//               busy     out  high in ADDR, WAIT and XFER
//               err      out  address out of range, valid while ready = 1
//
// Revision    : 1.0 - initial release
// ============================================================================
module toy_memory #(
    parameter int DEPTH_LOG2  = 5,
    parameter int WAIT_STATES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mem_en,
    input  logic       write_en,
    input  logic [7:0] d_out,
    output logic [7:0] d_in,
    output logic       ready,
    output logic       busy,
    output logic       err
);

    localparam int         c_DEPTH     = 2 ** DEPTH_LOG2;
    localparam logic [8:0] c_DEPTH_W   = 9'(c_DEPTH);
    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_WAIT = 3'd2,
        ST_XFER = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [7:0] r_addr;
    logic [7:0] w_addr_nxt;
    logic       r_wr;
    logic       w_wr_nxt;
    logic [7:0] r_d_in;
    logic [7:0] w_d_in_nxt;
    logic       r_ready;
    logic       w_ready_nxt;
    logic       r_err;
    logic       w_err_nxt;
    logic       w_mem_we;
    logic       w_in_range;

    // Storage has no reset: contents survive reset by design.
    logic [7:0] r_mem [c_DEPTH];

    // Widen by one bit so DEPTH_LOG2 = 8 (256 bytes) compares correctly.
    assign w_in_range = ({1'b0, r_addr} < c_DEPTH_W);

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 8'h00;
            r_wr    <= 1'b0;
            r_d_in  <= 8'h00;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_wr    <= w_wr_nxt;
            r_d_in  <= w_d_in_nxt;
            r_ready <= w_ready_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_wr_nxt    = r_wr;
        w_d_in_nxt  = r_d_in;
        w_ready_nxt = r_ready;
        w_err_nxt   = r_err;
        w_mem_we    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (mem_en) begin
                    w_addr_nxt  = d_out;
                    w_wr_nxt    = write_en;
                    w_cnt_nxt   = c_WAIT_LOAD;
                    w_state_nxt = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (!mem_en) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_IDLE;
                end else if (c_WAIT_LOAD != 4'd0) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_XFER;
                end
            end

            ST_WAIT: begin
                if (!mem_en) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt <= 4'd1) begin
                    // Counter reaches zero on this edge; WAIT therefore
                    // occupies exactly WAIT_STATES cycles.
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_XFER;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end

            ST_XFER: begin
                if (!mem_en) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                    if (r_wr) begin
                        w_mem_we = w_in_range;
                    end else begin
                        w_d_in_nxt = w_in_range ? r_mem[r_addr[DEPTH_LOG2-1:0]] : 8'hFF;
                    end
                end
            end

            ST_DONE: begin
                // ready rises on the first DONE edge and holds until the
                // processor releases mem_en.
                if (mem_en) begin
                    w_ready_nxt = 1'b1;
                    w_err_nxt   = ~w_in_range;
                end else begin
                    w_ready_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_cnt_nxt   = 4'd0;
                w_ready_nxt = 1'b0;
                w_err_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Memory write port; only an XFER with mem_en still high can write, and
    // reset forces IDLE, so a cancelled access never reaches this port.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr[DEPTH_LOG2-1:0]] <= d_out;
        end
    end

    assign d_in  = r_d_in;
    assign ready = r_ready;
    assign err   = r_err;
    assign busy  = (r_state == ST_ADDR) || (r_state == ST_WAIT) || (r_state == ST_XFER);

endmodule
`default_nettype wire
